// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and bit-timing helpers
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_period(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return bit_period(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser for asynchronous inputs, reset to the idle level
module uart_sync #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: start-edge detect, mid-bit sampling, valid/framing-error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PERIOD = half_period(CLK_FREQ, BAUD_RATE);
  localparam logic [31:0] BIT_LAST    = 32'(BIT_PERIOD - 1);
  localparam logic [31:0] HALF_LAST   = 32'(HALF_PERIOD - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

  logic        rx_s;
  logic        rx_prev_q;
  uart_state_e state_q, state_d;
  logic [31:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q, frame_error_d;

  uart_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d       = state_q;
    clk_count_d   = clk_count_q;
    bit_index_d   = bit_index_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Needs a high-to-low transition, so a held-low line cannot retrigger.
        if (rx_prev_q && !rx_s) begin
          state_d     = START;
          clk_count_d = '0;
        end
      end
      START: begin
        if (clk_count_q == HALF_LAST) begin
          clk_count_d = '0;
          state_d     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end
      DATA: begin
        if (clk_count_q == BIT_LAST) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s;
          if (bit_index_q == LAST_BIT) begin
            bit_index_d = '0;
            state_d     = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
        if (clk_count_q == BIT_LAST) begin
          clk_count_d = '0;
          state_d     = IDLE;
          if (rx_s == STOP_LEVEL) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q     <= 1'b1;
      state_q       <= IDLE;
      clk_count_q   <= '0;
      bit_index_q   <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_prev_q     <= rx_s;
      state_q       <= state_d;
      clk_count_q   <= clk_count_d;
      bit_index_q   <= bit_index_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frame checks of uart_rx against a frame-level model
module tb_uart_rx;

  localparam int CF  = 16;
  localparam int BR  = 1;
  localparam int BP  = CF / BR;
  localparam int HP  = BP / 2;
  localparam int LAT = HP + 9 * BP;
  localparam int CF2 = 1000;
  localparam int BR2 = 90;
  localparam int BP2 = CF2 / BR2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx2;
  logic [7:0] data_out, data_out2;
  logic       data_valid, frame_error, busy;
  logic       data_valid2, frame_error2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .frame_error(frame_error), .busy(busy)
  );

  uart_rx #(.CLK_FREQ(CF2), .BAUD_RATE(BR2)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .data_out(data_out2),
    .data_valid(data_valid2), .frame_error(frame_error2), .busy(busy2)
  );

  int         v_cyc[$], fe_cyc[$], pulse_cyc[$], rise_cyc[$], fall_cyc[$];
  logic [7:0] v_data[$], fe_dout[$], r2[$];
  int         both = 0;
  int         fe2_n = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin v_cyc.push_back(cyc); v_data.push_back(data_out); end
    if (frame_error) begin fe_cyc.push_back(cyc); fe_dout.push_back(data_out); end
    if (data_valid || frame_error) pulse_cyc.push_back(cyc);
    if (data_valid && frame_error) both++;
    if (busy && !busy_prev) rise_cyc.push_back(cyc);
    if (!busy && busy_prev) fall_cyc.push_back(cyc);
    busy_prev = busy;
    if (data_valid2) r2.push_back(data_out2);
    if (frame_error2) fe2_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    v_cyc.delete(); fe_cyc.delete(); pulse_cyc.delete(); rise_cyc.delete();
    fall_cyc.delete(); v_data.delete(); fe_dout.delete(); r2.delete();
    fe2_n = 0;
  endtask

  task automatic drive(input int ln, input logic v);
    if (ln == 0) rx = v; else rx2 = v;
  endtask

  task automatic hold(input int ln, input logic v, input int n);
    drive(ln, v);
    if (n > 0) begin repeat (n) @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int ln, input logic [7:0] d, input logic stop, input int bp);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) hold(ln, f[i], bp);
  endtask

  function automatic logic [31:0] qi(input int q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] qb(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? {24'd0, q[i]} : 32'hxxxx_xxxx;
  endfunction

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic [9:0] f;
    logic       stop;
    int         nfe;
    int         nframes;

    reset = 1'b0; rx = 1'b1; rx2 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    reset = 1'b1;
    hold(0, 1'b1, 20);

    clear();
    send_frame(0, 8'hA5, 1'b1, BP);
    hold(0, 1'b1, 20);
    check("t1_nvalid", v_data.size(), 1);
    check("t1_data", qb(v_data, 0), 8'hA5);
    check("t1_nferr", fe_cyc.size(), 0);
    check("t1_latency", qi(v_cyc, 0) - qi(rise_cyc, 0), LAT);
    check("t1_busy_span", qi(fall_cyc, 0) - qi(rise_cyc, 0), LAT);
    check("t1_hold", data_out, 8'hA5);

    clear();
    send_frame(0, 8'h00, 1'b1, BP);
    send_frame(0, 8'hFF, 1'b1, BP);
    hold(0, 1'b1, 20);
    check("t2_nvalid", v_data.size(), 2);
    check("t2_data0", qb(v_data, 0), 8'h00);
    check("t2_data1", qb(v_data, 1), 8'hFF);
    check("t2_spacing", qi(v_cyc, 1) - qi(v_cyc, 0), 10 * BP);

    clear();
    hold(0, 1'b0, 3);
    hold(0, 1'b1, 30);
    check("t3_nvalid", v_data.size(), 0);
    check("t3_nferr", fe_cyc.size(), 0);
    check("t3_nstart", rise_cyc.size(), 1);
    check("t3_busy_span", qi(fall_cyc, 0) - qi(rise_cyc, 0), HP);

    clear();
    send_frame(0, 8'h3C, 1'b1, BP);
    send_frame(0, 8'h81, 1'b0, BP);
    hold(0, 1'b0, 40);
    hold(0, 1'b1, 30);
    send_frame(0, 8'h7E, 1'b1, BP);
    hold(0, 1'b1, 20);
    check("t4_nferr", fe_cyc.size(), 1);
    check("t4_ferr_dout", qb(fe_dout, 0), 8'h3C);
    check("t4_ferr_latency", qi(fe_cyc, 0) - qi(rise_cyc, 1), LAT);
    check("t4_nstart", rise_cyc.size(), 3);
    check("t4_nvalid", v_data.size(), 2);
    check("t4_data1", qb(v_data, 1), 8'h7E);
    check("t4_hold", data_out, 8'h7E);

    clear();
    f = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      hold(0, f[i], HP);
      if (i == 4) begin
        check("t5_busy_pre", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_async_dout", data_out, 8'h00);
        check("t5_async_valid", data_valid, 1'b0);
        check("t5_async_busy", busy, 1'b0);
      end
      if (i == 9) reset = 1'b1;
      hold(0, f[i], BP - HP);
    end
    hold(0, 1'b1, 20);
    send_frame(0, 8'h12, 1'b1, BP);
    hold(0, 1'b1, 20);
    check("t5_nvalid", v_data.size(), 1);
    check("t5_data", qb(v_data, 0), 8'h12);
    check("t5_nferr", fe_cyc.size(), 0);

    clear();
    nfe = 0;
    nframes = 24;
    for (int k = 0; k < nframes; k++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(0, d, stop, BP);
      if (stop) exp_q.push_back(d); else nfe++;
      hold(0, 1'b1, BP * $urandom_range(stop ? 0 : 1, 3));
    end
    hold(0, 1'b1, 20);
    check("t6_nstart", rise_cyc.size(), nframes);
    check("t6_nvalid", v_data.size(), exp_q.size());
    check("t6_nferr", fe_cyc.size(), nfe);
    for (int i = 0; i < exp_q.size(); i++) check("t6_data", qb(v_data, i), exp_q[i]);
    for (int i = 0; i < nframes; i++)
      check("t6_latency", qi(pulse_cyc, i) - qi(rise_cyc, i), LAT);
    if (exp_q.size() > 0) check("t6_hold", data_out, exp_q[exp_q.size() - 1]);

    clear();
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hFF);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) send_frame(1, exp_q[i], 1'b1, BP2);
    hold(1, 1'b1, 3 * BP2);
    check("t7_nvalid", r2.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("t7_data", qb(r2, i), exp_q[i]);
    check("t7_nferr", fe2_n, 0);

    check("never_both", both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
